mod_counter_param: RTL and testbench

- Parametrised successor of the team's fixed 4-bit MOD counter.
- Counts modulo a runtime MOD value M, either up (0..M-1) or down (M-1..0).
- Adds synchronous load, a terminal-count pulse, a saturating wrap counter and error flags.
- Used as the general-purpose divider/timer primitive in counter and timer designs.

---
 rtl/mod_counter_param.sv | 102 ++++++++++
 tb/tb_mod_counter_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mod_counter_param.sv
// rtl/mod_counter_param.sv - runtime-modulus up/down counter with load, terminal count, wrap count and error flag
module mod_counter_param #(
   parameter int WIDTH      = 4,
   parameter int WRAP_WIDTH = 8
) (
   input  logic                  Clk_In,
   input  logic                  Reset_In,
   input  logic                  Start_Stopb_In,
   input  logic                  Up_Downb_In,
   input  logic [WIDTH-1:0]      MOD_Value_In,
   input  logic                  Load_In,
   input  logic [WIDTH-1:0]      Load_Value_In,
   output logic [WIDTH-1:0]      Count_Out,
   output logic                  Terminal_Count_Out,
   output logic [WRAP_WIDTH-1:0] Wrap_Count_Out,
   output logic                  Error_Out
);

   logic [WIDTH-1:0]      mod_q, mod_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic [WIDTH-1:0]      mod_m1;
   logic [WRAP_WIDTH-1:0] wrap_cnt_q, wrap_cnt_d;
   logic                  tc_q, tc_d;
   logic                  err_q, err_d;
   logic                  zero_err_q, zero_err_d;
   logic                  wrap;

   always_comb begin
      mod_d      = mod_q;
      count_d    = count_q;
      wrap_cnt_d = wrap_cnt_q;
      err_d      = 1'b0;
      zero_err_d = zero_err_q;
      wrap       = 1'b0;
      mod_m1     = mod_q - WIDTH'(1);

      // A stop re-arms the M==0 error so a restart reports it again
      if (!Start_Stopb_In) begin
         mod_d      = MOD_Value_In;
         zero_err_d = 1'b0;
      end

      if (Load_In) begin
         if (Load_Value_In < mod_q) begin
            count_d = Load_Value_In;
         end else begin
            count_d = '0;
            err_d   = 1'b1;
         end
      end else if (Start_Stopb_In) begin
         if (mod_q == '0) begin
            if (!zero_err_q) begin
               err_d      = 1'b1;
               zero_err_d = 1'b1;
            end
         end else if (Up_Downb_In) begin
            if (count_q >= mod_m1) begin
               count_d = '0;
               wrap    = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else if (count_q == '0) begin
            count_d = mod_m1;
            wrap    = 1'b1;
         end else if (count_q > mod_m1) begin
            count_d = mod_m1;
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end

      tc_d = wrap;
      if (wrap && (wrap_cnt_q != '1)) begin
         wrap_cnt_d = wrap_cnt_q + WRAP_WIDTH'(1);
      end
   end

   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         mod_q      <= MOD_Value_In;
         count_q    <= '0;
         wrap_cnt_q <= '0;
         tc_q       <= 1'b0;
         err_q      <= 1'b0;
         zero_err_q <= 1'b0;
      end else begin
         mod_q      <= mod_d;
         count_q    <= count_d;
         wrap_cnt_q <= wrap_cnt_d;
         tc_q       <= tc_d;
         err_q      <= err_d;
         zero_err_q <= zero_err_d;
      end
   end

   assign Count_Out          = count_q;
   assign Terminal_Count_Out = tc_q;
   assign Wrap_Count_Out     = wrap_cnt_q;
   assign Error_Out          = err_q;

endmodule

// File: tb/tb_mod_counter_param.sv
// tb/tb_mod_counter_param.sv - directed self-checking bench for mod_counter_param
module tb_mod_counter_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       up;
   logic [3:0] mod_val;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count, count2;
   logic       tc, tc2;
   logic [7:0] wrap_cnt;
   logic [1:0] wrap_cnt2;
   logic       err, err2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mod_counter_param #(.WIDTH(4), .WRAP_WIDTH(8)) dut (
      .Clk_In(clk), .Reset_In(rst), .Start_Stopb_In(start), .Up_Downb_In(up),
      .MOD_Value_In(mod_val), .Load_In(load), .Load_Value_In(load_val),
      .Count_Out(count), .Terminal_Count_Out(tc), .Wrap_Count_Out(wrap_cnt), .Error_Out(err)
   );

   mod_counter_param #(.WIDTH(4), .WRAP_WIDTH(2)) dut_w2 (
      .Clk_In(clk), .Reset_In(rst), .Start_Stopb_In(start), .Up_Downb_In(up),
      .MOD_Value_In(mod_val), .Load_In(load), .Load_Value_In(load_val),
      .Count_Out(count2), .Terminal_Count_Out(tc2), .Wrap_Count_Out(wrap_cnt2), .Error_Out(err2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int pulses;
   int exp_down [6] = '{4, 3, 2, 1, 0, 4};
   int exp_mod4 [4] = '{1, 2, 3, 0};

   initial begin
      rst = 1'b1; start = 1'b0; up = 1'b1; mod_val = 4'd10; load = 1'b0; load_val = 4'd0;
      step(); step();
      check("reset_count", count, 0);
      check("reset_tc", tc, 0);
      check("reset_wrap", wrap_cnt, 0);
      check("reset_err", err, 0);

      // Up count, M=10
      rst = 1'b0; start = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step();
         check("up_count", count, i);
         check("up_tc_low", tc, 0);
      end
      step();
      check("up_wrap_count", count, 0);
      check("up_wrap_tc", tc, 1);
      check("up_wrap_cnt1", wrap_cnt, 1);
      step();
      check("up_tc_one_cycle", tc, 0);
      for (int i = 0; i < 19; i++) step();
      check("up30_count", count, 0);
      check("up30_wraps", wrap_cnt, 3);

      // Load
      step(); step(); step();
      check("pre_load_count", count, 3);
      load = 1'b1; load_val = 4'd7;
      step();
      load = 1'b0;
      check("load_count", count, 7);
      check("load_tc", tc, 0);
      check("load_err", err, 0);
      step();
      check("after_load_count", count, 8);
      load = 1'b1; load_val = 4'd12;
      step();
      load = 1'b0;
      check("bad_load_count", count, 0);
      check("bad_load_err", err, 1);
      check("bad_load_tc", tc, 0);
      step();
      check("bad_load_err_pulse", err, 0);
      check("bad_load_next", count, 1);

      // Modulus change while running is ignored until a stop
      for (int i = 0; i < 5; i++) step();
      check("modchg_start", count, 6);
      mod_val = 4'd4;
      step(); check("modchg_7", count, 7);
      step(); check("modchg_8", count, 8);
      step(); check("modchg_9", count, 9);
      step(); check("modchg_wrap", count, 0); check("modchg_wrap_tc", tc, 1);
      start = 1'b0;
      step(); check("stop_hold", count, 0); check("stop_tc", tc, 0);
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("mod4_count", count, exp_mod4[i]);
         check("mod4_tc", tc, (i == 3) ? 1 : 0);
      end

      // Down count, M=5
      rst = 1'b1; start = 1'b0; mod_val = 4'd5;
      step();
      rst = 1'b0; start = 1'b1; up = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("down_count", count, exp_down[i]);
         if (tc) pulses++;
      end
      check("down_pulses", pulses, 2);
      check("down_wraps", wrap_cnt, 2);

      // M == 0
      rst = 1'b1; start = 1'b0; up = 1'b1; mod_val = 4'd0;
      step();
      rst = 1'b0; start = 1'b1;
      step(); check("m0_err", err, 1); check("m0_count", count, 0);
      step(); check("m0_err_once", err, 0);
      step(); check("m0_err_stays_low", err, 0); check("m0_tc", tc, 0);
      check("m0_wraps", wrap_cnt, 0);

      // M == 1
      start = 1'b0; mod_val = 4'd1;
      step(); check("m1_stop_tc", tc, 0);
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("m1_count", count, 0);
         check("m1_tc", tc, 1);
         check("m1_err", err, 0);
      end

      // Saturation with WRAP_WIDTH=2, then reset mid-count
      rst = 1'b1; start = 1'b0; mod_val = 4'd2;
      step();
      rst = 1'b0; start = 1'b1;
      for (int i = 0; i < 12; i++) step();
      check("sat_w2_wraps", wrap_cnt2, 3);
      check("sat_w8_wraps", wrap_cnt, 6);
      step();
      check("sat_count", count2, 1);
      rst = 1'b1; load = 1'b1; load_val = 4'd1;
      step();
      rst = 1'b0; load = 1'b0;
      check("midrst_count", count2, 0);
      check("midrst_wrap", wrap_cnt2, 0);
      check("midrst_tc", tc2, 0);
      check("midrst_err", err2, 0);
      check("midrst_count_w8", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
